// File: rtl/out_uart_pkg.sv
// out_uart_pkg: shared types and constants for the byte-output UART slice.
//   tx_state_t      - transmitter FSM states
//   DATA_BITS       - data bits per frame
//   FRAME_BITS_8N1  - bits per frame without parity
//   FRAME_BITS_8E1  - bits per frame with even parity
package out_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  localparam int unsigned DATA_BITS      = 8;
  localparam int unsigned FRAME_BITS_8N1 = DATA_BITS + 2;
  localparam int unsigned FRAME_BITS_8E1 = DATA_BITS + 3;

endpackage

// File: rtl/out_uart_fifo.sv
// out_uart_fifo: synchronous FIFO, combinational read of the head entry.
//   clk, rst      - clock, synchronous active-high reset
//   push, wdata   - write request and data; a push while full is accepted
//                   only when a pop happens in the same cycle
//   pop, rdata    - read request (ignored when empty) and head data
//   full, empty   - occupancy flags
//   level         - occupancy, 0..DEPTH
module out_uart_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == LW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];
  assign level   = count;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/out_uart_tx.sv
// out_uart_tx: toggle-strobe byte port -> FIFO -> LSB-first async serial.
// Frame is 8N1 by default, 8E1 when OUT_UART_PARITY_EN is defined.
//   clk, rst    - clock, synchronous active-high reset
//   in_dat      - byte, captured when in_ctl differs from its last sample
//   in_ctl      - toggle strobe, each level change is one byte
//   tx          - registered serial output, idle high
//   busy        - FIFO non-empty or frame in progress
//   ovf         - sticky, a byte was dropped on a full FIFO
//   fifo_level  - FIFO occupancy
module out_uart_tx
  import out_uart_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 16,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    in_dat,
  input  logic                          in_ctl,
  output logic                          tx,
  output logic                          busy,
  output logic                          ovf,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned   CW       = $clog2(CLK_DIV);
  localparam int unsigned   BW       = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_LOAD = CW'(CLK_DIV - 1);

  logic            ctl_q;
  logic            evt;
  logic            pop;
  logic            full;
  logic            empty;
  logic [7:0]      rdata;

  tx_state_t       state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_d;
`ifdef OUT_UART_PARITY_EN
  logic            par_q, par_d;
`endif

  assign evt  = (in_ctl != ctl_q);
  assign busy = (state_q != ST_IDLE) || (fifo_level != '0);

  out_uart_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (evt),
    .pop   (pop),
    .wdata (in_dat),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
`ifdef OUT_UART_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      ST_IDLE: begin
        pop = !empty;
      end
      ST_START: begin
        if (cnt_q == '0) begin
          cnt_d   = CNT_LOAD;
          bit_d   = '0;
          state_d = ST_DATA;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_DATA: begin
        if (cnt_q == '0) begin
          cnt_d   = CNT_LOAD;
          shift_d = shift_q >> 1;
          if (bit_q == BW'(DATA_BITS - 1)) begin
`ifdef OUT_UART_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
`ifdef OUT_UART_PARITY_EN
      ST_PARITY: begin
        if (cnt_q == '0) begin
          cnt_d   = CNT_LOAD;
          state_d = ST_STOP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
`endif
      ST_STOP: begin
        if (cnt_q == '0) begin
          if (!empty) begin
            pop = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Loading a byte is shared by IDLE and the end of STOP (gapless frames).
    if (pop) begin
      shift_d = rdata;
      cnt_d   = CNT_LOAD;
      state_d = ST_START;
`ifdef OUT_UART_PARITY_EN
      par_d   = ^rdata;
`endif
    end

    // tx is registered, so it is derived from the state being entered.
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
`ifdef OUT_UART_PARITY_EN
      ST_PARITY: tx_d = par_d;
`endif
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx      <= 1'b1;
      ctl_q   <= 1'b0;
      ovf     <= 1'b0;
`ifdef OUT_UART_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx      <= tx_d;
      ctl_q   <= in_ctl;
      if (evt && full && !pop) begin
        ovf <= 1'b1;
      end
`ifdef OUT_UART_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_out_uart_tx.sv
// tb_out_uart_tx: self-checking bench for out_uart_tx (CLK_DIV=4, FIFO_DEPTH=4).
// Honours OUT_UART_PARITY_EN for the expected frame format.
module tb_out_uart_tx;

  localparam int CLK_DIV = 4;
  localparam int DEPTH   = 4;
`ifdef OUT_UART_PARITY_EN
  localparam bit PAR   = 1'b1;
  localparam int NBITS = 11;
`else
  localparam bit PAR   = 1'b0;
  localparam int NBITS = 10;
`endif
  localparam int FL = NBITS * CLK_DIV;

  logic       clk    = 1'b0;
  logic       rst    = 1'b1;
  logic       in_ctl = 1'b0;
  logic [7:0] in_dat = 8'h00;
  logic       tx;
  logic       busy;
  logic       ovf;
  logic [2:0] fifo_level;

  always #5 clk = ~clk;

  out_uart_tx #(
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_dat     (in_dat),
    .in_ctl     (in_ctl),
    .tx         (tx),
    .busy       (busy),
    .ovf        (ovf),
    .fifo_level (fifo_level)
  );

  int         cyc      = 0;
  int         n_checks = 0;
  int         n_fail   = 0;
  int         peak     = 0;
  int         ovf_t    = -1;
  logic       m_ctl    = 1'b0;
  logic       cur_ctl  = 1'b0;
  int         push_t[$];
  int         start_t[$];
  logic [7:0] bytes[$];

  // Occupancy in cycle c: bytes written before c minus bytes popped before c
  // (a frame's byte is popped in the cycle preceding its start bit).
  function automatic int level_at(int c);
    int n = 0;
    foreach (push_t[i]) if (push_t[i] < c) n++;
    foreach (start_t[i]) if (start_t[i] - 1 < c) n--;
    return n;
  endfunction

  function automatic bit in_frame(int c);
    foreach (start_t[k]) if (c >= start_t[k] && c < start_t[k] + FL) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic exp_tx(int c);
    foreach (start_t[k]) begin
      if (c >= start_t[k] && c < start_t[k] + FL) begin
        int b;
        b = (c - start_t[k]) / CLK_DIV;
        if (b == 0) return 1'b0;
        if (b <= 8) return bytes[k][b-1];
        if (PAR && b == 9) return ^bytes[k];
        return 1'b1;
      end
    end
    return 1'b1;
  endfunction

  // A byte seen in cycle cyc is kept if there is room or a pop frees a slot
  // in the same cycle. Its frame starts two cycles later, or right after the
  // previous frame, whichever is later.
  task automatic model_event(input logic [7:0] d);
    int lvl;
    bit pop_now;
    int s;
    lvl = level_at(cyc);
    pop_now = 1'b0;
    foreach (start_t[i]) if (start_t[i] == cyc + 1) pop_now = 1'b1;
    if (lvl < DEPTH || pop_now) begin
      s = cyc + 2;
      if (start_t.size() > 0 && start_t[$] + FL > s) s = start_t[$] + FL;
      push_t.push_back(cyc);
      start_t.push_back(s);
      bytes.push_back(d);
    end else if (ovf_t < 0) begin
      ovf_t = cyc + 1;
    end
  endtask

  task automatic model_reset();
    push_t.delete();
    start_t.delete();
    bytes.delete();
    ovf_t = -1;
    m_ctl = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic ctl, input logic [7:0] dat);
    @(posedge clk);
    #1;
    rst    = r;
    in_ctl = ctl;
    in_dat = dat;
    if (!r && ctl != m_ctl) begin
      m_ctl = ctl;
      model_event(dat);
    end
    @(negedge clk);
    chk("tx", 32'(tx), 32'(exp_tx(cyc)));
    chk("busy", 32'(busy), 32'((level_at(cyc) > 0) || in_frame(cyc)));
    chk("fifo_level", 32'(fifo_level), 32'(level_at(cyc)));
    chk("ovf", 32'(ovf), 32'(ovf_t >= 0 && cyc >= ovf_t));
    if (int'(fifo_level) > peak) peak = int'(fifo_level);
    if (r) model_reset();
    cyc++;
  endtask

  task automatic toggle(input logic [7:0] d);
    cur_ctl = ~cur_ctl;
    step(1'b0, cur_ctl, d);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, cur_ctl, 8'($urandom));
  endtask

  initial begin
    repeat (3) step(1'b1, 1'b0, 8'h00);

    // single byte, then level held with changing data (no events)
    toggle(8'h55);
    idle(FL + 6);

    // parity-relevant bytes
    toggle(8'h07);
    idle(FL + 6);
    toggle(8'h03);
    idle(FL + 6);

    // back-to-back
    peak = 0;
    toggle(8'h41);
    toggle(8'h42);
    toggle(8'h43);
    idle(3 * FL + 6);
    chk("b2b_peak_level", 32'(peak), 32'd2);

    // overflow: six consecutive toggles into a 4-deep FIFO
    repeat (6) toggle(8'($urandom));
    idle(6 * FL + 6);
    chk("ovf_sticky", 32'(ovf), 32'd1);

    // reset during data bit 3
    toggle(8'($urandom));
    idle(18);
    cur_ctl = 1'b0;
    step(1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b0, 8'($urandom));
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    idle(3);
    toggle(8'($urandom));
    idle(FL + 6);

    // random traffic
    repeat (80) begin
      if ($urandom_range(0, 2) == 0) toggle(8'($urandom));
      else idle(1);
    end
    idle(6 * FL + 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
